// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous-comparison FIFO (write side, read side, comparator).
package async_fifo_pkg;

  localparam int ADDRSIZE_DEF = 8;

  typedef logic [ADDRSIZE_DEF-1:0] ptr_t;

  // Wide enough for any pointer width in use; callers cast the result down.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_preset_2ff.sv
// Two-flop flag synchronizer: async preset sets both stages, then 0 is shifted in per clock.
module sync_preset_2ff (
  input  logic clk,
  input  logic clr_n,
  input  logic preset_n,
  output logic q
);

  logic q2;

  // Clear wins over preset so a reset always leaves the flag low.
  always_ff @(posedge clk or negedge clr_n or negedge preset_n) begin
    if (!clr_n) begin
      q  <= 1'b0;
      q2 <= 1'b0;
    end else if (!preset_n) begin
      q  <= 1'b1;
      q2 <= 1'b1;
    end else begin
      q  <= q2;
      q2 <= 1'b0;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and full flag of the async-comparison FIFO.
// Optional sticky overflow flag enabled by defining WPTR_FULL_OVF_EN.
module wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                wclk,
  input  logic                dirclr_n,
  input  logic                winc,
  input  logic                afull_n,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE-1:0] wptr,
  output logic                wfull,
  output logic                wovf
);

  logic [ADDRSIZE-1:0] wbin_next;
  logic [ADDRSIZE-1:0] wgray_next;

  assign wen        = winc & ~wfull;
  assign wbin_next  = waddr + 1'b1;
  assign wgray_next = ADDRSIZE'(bin2gray(32'(wbin_next)));

  always_ff @(posedge wclk or negedge dirclr_n) begin
    if (!dirclr_n) begin
      waddr <= '0;
      wptr  <= '0;
    end else if (wen) begin
      waddr <= wbin_next;
      wptr  <= wgray_next;
    end
  end

  // wfull comes straight from the flop chain; no path from wptr.
  sync_preset_2ff u_full_sync (
    .clk      (wclk),
    .clr_n    (dirclr_n),
    .preset_n (afull_n),
    .q        (wfull)
  );

`ifdef WPTR_FULL_OVF_EN
  always_ff @(posedge wclk or negedge dirclr_n) begin
    if (!dirclr_n)
      wovf <= 1'b0;
    else if (winc && wfull)
      wovf <= 1'b1;
  end
`else
  assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDRSIZE=3): directed steps then randomized traffic.
module tb_wptr_full;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          wclk = 1'b0;
  logic          dirclr_n;
  logic          winc;
  logic          afull_n;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW-1:0] wptr;
  logic          wfull;
  logic          wovf;

  int checks   = 0;
  int failures = 0;

  // Reference model: writes accepted so far, edges left until wfull clears, sticky overflow.
  int wcount;
  int fcnt;
  bit ovf_m;
  int prev_gray;

  wptr_full #(.ADDRSIZE(AW)) dut (
    .wclk     (wclk),
    .dirclr_n (dirclr_n),
    .winc     (winc),
    .afull_n  (afull_n),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wovf     (wovf)
  );

  always #5 wclk = ~wclk;

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int ovf_exp();
`ifdef WPTR_FULL_OVF_EN
    return int'(ovf_m);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 32'(wcount));
    chk({tag, ".wptr"},  32'(wptr),  32'(gray_of(wcount)));
    chk({tag, ".wfull"}, 32'(wfull), 32'(fcnt > 0));
    chk({tag, ".wen"},   32'(wen),   32'(winc && fcnt == 0));
    chk({tag, ".wovf"},  32'(wovf),  32'(ovf_exp()));
  endtask

  // One clock edge: advance the model from pre-edge inputs, then check just after the edge.
  task automatic cycle(input string tag);
    bit acc;
    @(posedge wclk);
    acc = winc && (fcnt == 0);
    if (winc && fcnt != 0) ovf_m = 1'b1;
    if (acc) wcount = (wcount + 1) % DEPTH;
    if (!afull_n) fcnt = 2;
    else if (fcnt > 0) fcnt--;
    #1;
    chk_all(tag);
    chk({tag, ".gray_step"}, 32'($countones(wptr ^ AW'(prev_gray))), acc ? 32'd1 : 32'd0);
    prev_gray = gray_of(wcount);
  endtask

  task automatic model_reset();
    wcount = 0; fcnt = 0; ovf_m = 1'b0; prev_gray = 0;
  endtask

  initial begin
    dirclr_n = 1'b0;
    winc     = 1'b0;
    afull_n  = 1'b1;
    model_reset();
    #12;
    chk_all("reset");
    dirclr_n = 1'b1;

    // Eight sequential writes wrap the pointer: gray 1,3,2,6,7,5,4,0.
    winc = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle("seq");
    chk("wrap.wptr", 32'(wptr), 32'd0);

    // Full assertion between edges: no clock needed, write blocked.
    #2;
    afull_n = 1'b0;
    fcnt    = 2;
    #1;
    chk("afull_async.wfull", 32'(wfull), 32'd1);
    chk("afull_async.wen",   32'(wen),   32'd0);
    cycle("blocked1");
    cycle("blocked2");
    chk("blocked.waddr_hold", 32'(waddr), 32'd0);

    // Release: wfull holds through one edge, clears after the second.
    #2;
    afull_n = 1'b1;
    #1;
    chk("release.wfull_now", 32'(wfull), 32'd1);
    cycle("release1");
    chk("release1.wfull", 32'(wfull), 32'd1);
    cycle("release2");
    chk("release2.wfull", 32'(wfull), 32'd0);
    cycle("first_after_release");
    chk("first_after_release.waddr", 32'(waddr), 32'd1);
    chk("ovf_sticky", 32'(wovf), 32'(ovf_exp()));

    // Reset mid-operation after five writes (waddr=5, wptr=7).
    winc = 1'b0;
    dirclr_n = 1'b0;
    model_reset();
    #1;
    dirclr_n = 1'b1;
    winc = 1'b1;
    for (int i = 0; i < 5; i++) cycle("pre_rst");
    chk("pre_rst.waddr", 32'(waddr), 32'd5);
    chk("pre_rst.wptr",  32'(wptr),  32'd7);
    #2;
    dirclr_n = 1'b0;
    model_reset();
    #1;
    chk_all("mid_rst");
    #1;
    dirclr_n = 1'b1;

    // Randomized traffic with afull_n pulses landing mid-cycle.
    for (int n = 0; n < 400; n++) begin
      winc = 1'($urandom_range(0, 3) != 0);
      if (afull_n && $urandom_range(0, 7) == 0) begin
        afull_n = 1'b0;
        fcnt    = 2;
      end else if (!afull_n && $urandom_range(0, 2) == 0) begin
        afull_n = 1'b1;
      end
      #1;
      chk("rand.wfull_mid", 32'(wfull), 32'(fcnt > 0));
      chk("rand.wen_mid",   32'(wen),   32'(winc && fcnt == 0));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag stage of the asynchronous-comparison FIFO. Maintains the binary write address for the dual-port RAM and drives the Gray-coded write pointer into the async comparator. Consumes the comparator's active-low `afull_n` and converts it into a write-clock-domain `wfull` flag that blocks further writes. Sits in the write clock domain between the producer and the comparator/RAM.

## Interface
Parameters:
- ADDRSIZE, 8, RAM address width; pointers are ADDRSIZE bits, depth 2^ADDRSIZE

Ports:
- wclk  input  1  write-domain clock, rising edge
- dirclr_n  input  1  reset dirclr_n, asynchronous, active-low
- winc  input  1  write request from producer
- afull_n  input  1  almost-full/full indication from comparator, active-low, asynchronous to wclk
- wen  output  1  RAM write enable, = winc & ~wfull (combinational)
- waddr  output  ADDRSIZE  registered binary write address to RAM
- wptr  output  ADDRSIZE  registered Gray write pointer to comparator
- wfull  output  1  full flag, write domain
- wovf  output  1  sticky overflow flag (see Configuration)

## Operation
- Reset (dirclr_n low): waddr=0, wptr=0, wfull=0, internal wfull2=0, wovf=0; takes effect immediately, overrides afull_n.
- Accepted write: winc=1 and wfull=0. On the wclk edge: wbin_next = waddr+1 (mod 2^ADDRSIZE); waddr<=wbin_next; wptr<=wbin_next ^ (wbin_next>>1).
- Rejected write: winc=1 and wfull=1. Pointers hold; wen=0.
- wptr differs from its previous value in exactly one bit per accepted write, including the wrap 2^ADDRSIZE-1 -> 0 (Gray 100..0 -> 000..0).
- Full flag: two-flop chain {wfull, wfull2} with asynchronous preset driven by afull_n.
  - afull_n low: {wfull,wfull2} preset to 11 asynchronously, no clock required.
  - afull_n high: on each wclk edge {wfull,wfull2} <= {wfull2, 0}.
  - dirclr_n takes priority over afull_n preset.
- wfull is computed from flops only; no combinational path from wptr to wfull.
- Simultaneous afull_n fall and accepted write on the same edge: the write completes (pointer advances), wfull reads 1 afterwards; the comparator guarantees one slot of slack.

## Timing
- waddr/wptr latency: 1 wclk after accepted write.
- wfull assertion: asynchronous, within propagation delay of afull_n falling.
- wfull deassertion: afull_n rising followed by 2 rising wclk edges; first write accepted in the cycle where wfull=0.
- wen combinational from winc and wfull, same cycle.
- Reset release: first accepted write possible on the first wclk edge after dirclr_n rises (no synchronizer inside; reset deassertion sync handled upstream).

## Configuration
- WPTR_FULL_OVF_EN defined: wovf set on any wclk edge with winc=1 and wfull=1; stays 1 until dirclr_n low.
- Not defined: wovf tied to 0; no overflow flop; port remains for interface stability.

## Structure
- Shared package async_fifo_pkg: ADDRSIZE default constant, bin2gray function, pointer typedef sized by ADDRSIZE; shared with the read-side stage and comparator.
- Sub-module sync_preset_2ff: two-flop synchronizer with async active-low preset and async active-low clear; reused by the read-side empty flag.

## Test plan
- Reset mid-operation: after 5 writes (waddr=5, wptr=7), pull dirclr_n low -> waddr=0, wptr=0, wfull=0, wovf=0 immediately without clock.
- Sequential writes, ADDRSIZE=3: 8 accepted writes from 0 -> wptr sequence 1,3,2,6,7,5,4,0; waddr 1..7,0; single-bit change each step.
- Full assertion: winc=1, drop afull_n between clock edges -> wfull=1 before next edge; wen=0; waddr holds.
- Full release: afull_n rises -> wfull stays 1 through first wclk edge, 0 after second; write accepted next edge.
- Overflow (macro on): hold winc=1 for 2 cycles while wfull=1 -> wovf=1, remains 1 after wfull clears; macro off -> wovf=0 throughout.
